// File: rtl/motor_bridge_pkg.sv
// Shared types and constants for the H-bridge output sequencer.
// Holds the per-channel state/target enums and the control-code decode.
package motor_bridge_pkg;

    localparam int CTL_W = 2;

    localparam logic [CTL_W-1:0] CTL_COAST = 2'b00;
    localparam logic [CTL_W-1:0] CTL_FWD   = 2'b01;
    localparam logic [CTL_W-1:0] CTL_REV   = 2'b10;
    localparam logic [CTL_W-1:0] CTL_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_REV,
        ST_FAULT
    } chanState_t;

    typedef enum logic [1:0] {
        TGT_COAST,
        TGT_BRAKE,
        TGT_FWD,
        TGT_REV
    } target_t;

    // Measure window beats everything, then slow-decay brake, then direction.
    function automatic target_t decodeTarget(input logic [CTL_W-1:0] code,
                                             input logic             pwm,
                                             input logic             measure);
        target_t tgt;
        if (measure || code == CTL_COAST) begin
            tgt = TGT_COAST;
        end else if (!pwm || code == CTL_BRAKE) begin
            tgt = TGT_BRAKE;
        end else if (code == CTL_FWD) begin
            tgt = TGT_FWD;
        end else begin
            tgt = TGT_REV;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/motor_bridge_chan.sv
// One H-bridge channel: fault synchronizer, target decode, drive FSM with
// dead-time idle counter, and registered A/B/C/fault outputs.
module motor_bridge_chan
    import motor_bridge_pkg::*;
#(
    parameter int DT_W = 4
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Enable,
    input  logic [DT_W-1:0]  DeadTime,
    input  logic [CTL_W-1:0] Control,
    input  logic             Pwm,
    input  logic             Measure,
    input  logic             FaultN,
    input  logic             FaultClr,
    output logic             MotorA,
    output logic             MotorB,
    output logic             MotorC,
    output logic             FaultStat
);

    chanState_t      state;
    chanState_t      nextState;
    target_t         target;
    logic            faultMeta;
    logic            faultSync;
    logic [DT_W-1:0] idleCnt;
    logic [DT_W-1:0] idleCntNext;
    logic            deadTimeMet;
    logic            driveA;
    logic            driveB;
    logic            driveC;

    function automatic logic [DT_W-1:0] satInc(input logic [DT_W-1:0] v);
        return (v == {DT_W{1'b1}}) ? v : v + DT_W'(1);
    endfunction

    // FaultN is asynchronous to Clk; both flops idle high so reset is fault-free.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            faultMeta <= 1'b1;
            faultSync <= 1'b1;
        end else begin
            faultMeta <= FaultN;
            faultSync <= faultMeta;
        end
    end

    assign target      = decodeTarget(Control, Pwm, Measure);
    assign deadTimeMet = (idleCnt >= DeadTime);

    always_comb begin
        nextState   = state;
        idleCntNext = '0;
        driveA      = 1'b0;
        driveB      = 1'b0;
        driveC      = 1'b0;

        if (!faultSync) begin
            nextState = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (FaultClr) begin
                nextState = ST_IDLE;
            end
        end else if (!Enable) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (deadTimeMet && target == TGT_FWD) begin
                        nextState = ST_FWD;
                    end else if (deadTimeMet && target == TGT_REV) begin
                        nextState = ST_REV;
                    end
                end
                ST_FWD: begin
                    if (target != TGT_FWD) begin
                        nextState = ST_IDLE;
                    end
                end
                ST_REV: begin
                    if (target != TGT_REV) begin
                        nextState = ST_IDLE;
                    end
                end
                default: nextState = ST_IDLE;
            endcase
        end

        // Counter reads zero in the first idle cycle, so DeadTime=N gives N+1 idle cycles.
        if (state == ST_IDLE) begin
            idleCntNext = satInc(idleCnt);
        end

        // Outputs decode the next state so turn-off lands one cycle after the input change.
        driveA = (nextState == ST_FWD);
        driveB = (nextState == ST_REV);
        driveC = (nextState == ST_FAULT) ||
                 (nextState == ST_IDLE && (!Enable || target == TGT_COAST));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state     <= ST_IDLE;
            idleCnt   <= '1;
            MotorA    <= 1'b0;
            MotorB    <= 1'b0;
            MotorC    <= 1'b1;
            FaultStat <= 1'b0;
        end else begin
            state     <= nextState;
            idleCnt   <= idleCntNext;
            MotorA    <= driveA;
            MotorB    <= driveB;
            MotorC    <= driveC;
            FaultStat <= (nextState == ST_FAULT);
        end
    end

endmodule

// File: rtl/motor_bridge_ctrl.sv
// N-channel H-bridge output sequencer: one independent channel per motor,
// sharing only Enable, DeadTime and FaultClr.
module motor_bridge_ctrl
    import motor_bridge_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DT_W     = 4
) (
    input  logic                      Clk,
    input  logic                      ResetN,
    input  logic                      Enable,
    input  logic [DT_W-1:0]           DeadTime,
    input  logic [CTL_W*CHANNELS-1:0] Control,
    input  logic [CHANNELS-1:0]       Pwm,
    input  logic [CHANNELS-1:0]       Measure,
    input  logic [CHANNELS-1:0]       FaultN,
    input  logic                      FaultClr,
    output logic [CHANNELS-1:0]       MotorA,
    output logic [CHANNELS-1:0]       MotorB,
    output logic [CHANNELS-1:0]       MotorC,
    output logic [CHANNELS-1:0]       FaultStat
);

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        motor_bridge_chan #(
            .DT_W(DT_W)
        ) uChan (
            .Clk      (Clk),
            .ResetN   (ResetN),
            .Enable   (Enable),
            .DeadTime (DeadTime),
            .Control  (Control[CTL_W*i +: CTL_W]),
            .Pwm      (Pwm[i]),
            .Measure  (Measure[i]),
            .FaultN   (FaultN[i]),
            .FaultClr (FaultClr),
            .MotorA   (MotorA[i]),
            .MotorB   (MotorB[i]),
            .MotorC   (MotorC[i]),
            .FaultStat(FaultStat[i])
        );
    end

endmodule

// File: tb/tb_motor_bridge_ctrl.sv
// Directed and randomized bench for motor_bridge_ctrl against a
// direction/idle-time reference model of each bridge channel.
module tb_motor_bridge_ctrl;

    localparam int CHANNELS = 4;
    localparam int DT_W     = 4;
    localparam int IDLE_CAP = 1000;

    logic                    Clk      = 1'b0;
    logic                    ResetN   = 1'b0;
    logic                    Enable   = 1'b0;
    logic                    FaultClr = 1'b0;
    logic [DT_W-1:0]         DeadTime = '0;
    logic [2*CHANNELS-1:0]   Control  = '0;
    logic [CHANNELS-1:0]     Pwm      = '1;
    logic [CHANNELS-1:0]     Measure  = '0;
    logic [CHANNELS-1:0]     FaultN   = '1;
    logic [CHANNELS-1:0]     MotorA;
    logic [CHANNELS-1:0]     MotorB;
    logic [CHANNELS-1:0]     MotorC;
    logic [CHANNELS-1:0]     FaultStat;

    int checks   = 0;
    int failures = 0;

    // Model: drive 0=off, 1=forward, 2=reverse; idleFor = idle cycles already spent.
    int                  drive   [CHANNELS];
    int                  idleFor [CHANNELS];
    bit                  faulted [CHANNELS];
    bit                  fltDly1 [CHANNELS];
    bit                  fltDly2 [CHANNELS];
    logic [CHANNELS-1:0] expA, expB, expC, expF;

    motor_bridge_ctrl #(
        .CHANNELS(CHANNELS),
        .DT_W    (DT_W)
    ) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Enable   (Enable),
        .DeadTime (DeadTime),
        .Control  (Control),
        .Pwm      (Pwm),
        .Measure  (Measure),
        .FaultN   (FaultN),
        .FaultClr (FaultClr),
        .MotorA   (MotorA),
        .MotorB   (MotorB),
        .MotorC   (MotorC),
        .FaultStat(FaultStat)
    );

    always #5 Clk = ~Clk;

    // 0 coast, 1 brake, 2 forward, 3 reverse
    function automatic int wantOf(int ch);
        logic [1:0] code;
        code = Control[2*ch +: 2];
        if (Measure[ch] || code == 2'b00) return 0;
        if (!Pwm[ch] || code == 2'b11) return 1;
        return (code == 2'b01) ? 2 : 3;
    endfunction

    function automatic void modelReset();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            drive[ch]   = 0;
            idleFor[ch] = IDLE_CAP;
            faulted[ch] = 1'b0;
            fltDly1[ch] = 1'b1;
            fltDly2[ch] = 1'b1;
        end
        expA = '0;
        expB = '0;
        expC = '1;
        expF = '0;
    endfunction

    function automatic void modelEdge();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            int w;
            int newDrive;
            bit newFault;
            bit synced;
            bit wasIdle;
            w        = wantOf(ch);
            synced   = fltDly2[ch];
            fltDly2[ch] = fltDly1[ch];
            fltDly1[ch] = FaultN[ch];
            wasIdle  = !faulted[ch] && drive[ch] == 0;
            newFault = faulted[ch];
            newDrive = drive[ch];
            if (!synced) begin
                newFault = 1'b1;
                newDrive = 0;
            end else if (faulted[ch]) begin
                if (FaultClr) newFault = 1'b0;
            end else if (!Enable) begin
                newDrive = 0;
            end else if (drive[ch] == 1 && w != 2) begin
                newDrive = 0;
            end else if (drive[ch] == 2 && w != 3) begin
                newDrive = 0;
            end else if (drive[ch] == 0 && w >= 2 && idleFor[ch] >= int'(DeadTime)) begin
                newDrive = w - 1;
            end
            if (!newFault && newDrive == 0) begin
                idleFor[ch] = wasIdle ? ((idleFor[ch] < IDLE_CAP) ? idleFor[ch] + 1 : IDLE_CAP) : 0;
            end
            faulted[ch] = newFault;
            drive[ch]   = newDrive;
            expA[ch] = (drive[ch] == 1);
            expB[ch] = (drive[ch] == 2);
            expC[ch] = faulted[ch] || (drive[ch] == 0 && (!Enable || w == 0));
            expF[ch] = faulted[ch];
        end
    endfunction

    task automatic chk(input string tag, input logic [CHANNELS-1:0] obs, input logic [CHANNELS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        modelEdge();
        #1;
        chk({tag, ".A"}, MotorA, expA);
        chk({tag, ".B"}, MotorB, expB);
        chk({tag, ".C"}, MotorC, expC);
        chk({tag, ".F"}, FaultStat, expF);
        chk({tag, ".AandB"}, MotorA & MotorB, '0);
    endtask

    initial begin
        modelReset();

        // T1: reset values, then first drive needs no dead-time
        #12;
        chk("rst.A", MotorA, 4'h0);
        chk("rst.B", MotorB, 4'h0);
        chk("rst.C", MotorC, 4'hF);
        chk("rst.F", FaultStat, 4'h0);
        Enable  = 1'b1;
        Control = 8'h01;
        ResetN  = 1'b1;
        step("t1");
        chkBit("t1.A0", MotorA[0], 1'b1);

        // T2: forward to reverse gap of DeadTime+1 cycles
        DeadTime     = 4'd3;
        Control[3:2] = 2'b01;
        step("t2fwd");
        chkBit("t2.A1", MotorA[1], 1'b1);
        Control[3:2] = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step("t2gap");
            chkBit("t2gap.A1", MotorA[1], 1'b0);
            chkBit("t2gap.B1", MotorB[1], 1'b0);
        end
        step("t2rev");
        chkBit("t2rev.B1", MotorB[1], 1'b1);

        // T3: one-cycle PWM low on channel 0
        DeadTime = 4'd2;
        Pwm[0]   = 1'b0;
        step("t3brk");
        chkBit("t3brk.A0", MotorA[0], 1'b0);
        chkBit("t3brk.C0", MotorC[0], 1'b0);
        Pwm[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step("t3idle");
            chkBit("t3idle.A0", MotorA[0], 1'b0);
            chkBit("t3idle.C0", MotorC[0], 1'b0);
        end
        step("t3on");
        chkBit("t3on.A0", MotorA[0], 1'b1);

        // T4: BEMF window on channel 2 in reverse
        Control[5:4] = 2'b10;
        step("t4rev");
        chkBit("t4rev.B2", MotorB[2], 1'b1);
        Measure[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step("t4win");
            chkBit("t4win.B2", MotorB[2], 1'b0);
            chkBit("t4win.C2", MotorC[2], 1'b1);
        end
        Measure[2] = 1'b0;
        step("t4back");
        chkBit("t4back.B2", MotorB[2], 1'b1);

        // T5: fault latch, ignored clear, real clear, dead-time resume
        Control[7:6] = 2'b01;
        step("t5fwd");
        chkBit("t5fwd.A3", MotorA[3], 1'b1);
        FaultN[3] = 1'b0;
        step("t5s1");
        step("t5s2");
        step("t5s3");
        chkBit("t5.C3", MotorC[3], 1'b1);
        chkBit("t5.F3", FaultStat[3], 1'b1);
        FaultClr = 1'b1;
        step("t5clrLow");
        FaultClr = 1'b0;
        chkBit("t5clrLow.F3", FaultStat[3], 1'b1);
        FaultN[3] = 1'b1;
        step("t5sync1");
        step("t5sync2");
        chkBit("t5sync.F3", FaultStat[3], 1'b1);
        FaultClr = 1'b1;
        step("t5clr");
        FaultClr = 1'b0;
        chkBit("t5clr.F3", FaultStat[3], 1'b0);
        chkBit("t5clr.A3", MotorA[3], 1'b0);
        step("t5dt1");
        step("t5dt2");
        chkBit("t5dt.A3", MotorA[3], 1'b0);
        step("t5on");
        chkBit("t5on.A3", MotorA[3], 1'b1);

        // T6: global disable, then counter saturation allows immediate drive
        Enable = 1'b0;
        step("t6off");
        chk("t6off.C", MotorC, 4'hF);
        chk("t6off.A", MotorA, 4'h0);
        DeadTime = 4'd15;
        Control  = 8'h55;
        for (int k = 0; k < 21; k++) step("t6idle");
        Enable = 1'b1;
        step("t6on");
        chk("t6on.A", MotorA, 4'hF);

        // Randomized traffic against the model
        DeadTime = 4'd1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) Control = 8'($urandom);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                Pwm[ch]     = ($urandom_range(0, 5) != 0);
                Measure[ch] = ($urandom_range(0, 9) == 0);
                FaultN[ch]  = ($urandom_range(0, 24) != 0);
            end
            FaultClr = ($urandom_range(0, 4) == 0);
            Enable   = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) DeadTime = 4'($urandom_range(0, 6));
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
